// File: rtl/ballot_request_queue.sv
// Ballot request queue: round-robin merge of four kiosk request streams into a
// FIFO that drains to the election core. Define QUEUE_STATS_EN for stall/drop counters.

module ballot_kiosk_lane #(
  parameter logic [1:0] BOX = 2'd0
) (
  input  logic [1:0] mode,
  input  logic [3:0] index,
  input  logic [1:0] cand,
  output logic [9:0] entry,
  output logic       bad
);
  assign entry = {mode, BOX, index, cand};
  assign bad   = mode[1];
endmodule

module ballot_request_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [3:0]    k_valid,
  input  logic [7:0]    k_mode,
  input  logic [15:0]   k_uid,
  input  logic [7:0]    k_cand,
  output logic [3:0]    k_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_mode,
  output logic [5:0]    out_userID,
  output logic [1:0]    out_candidate,
  output logic [AW:0]   level,
  output logic          bad_cmd
`ifdef QUEUE_STATS_EN
  ,
  output logic [15:0]   stall_cycles,
  output logic [7:0]    drop_count
`endif
);
  localparam int NUM_LANES = 4;
  localparam int EW        = 10;

  logic [NUM_LANES-1:0][EW-1:0] entry;
  logic [NUM_LANES-1:0]         bad_lane;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ballot_kiosk_lane #(.BOX(2'(g))) u_lane (
      .mode  (k_mode[2*g +: 2]),
      .index (k_uid[4*g +: 4]),
      .cand  (k_cand[2*g +: 2]),
      .entry (entry[g]),
      .bad   (bad_lane[g])
    );
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [1:0]    rr_ptr;
  logic          full, gnt_any, push, pop;
  logic [1:0]    gidx;
  logic [AW:0]   lvl_nx;
  logic [EW-1:0] head_nx;

  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign push      = gnt_any && !bad_lane[gidx];
  assign lvl_nx    = level + (AW+1)'(push) - (AW+1)'(pop);

  // Search starts one past the last winner; a full queue blocks even if popping.
  always_comb begin
    k_ready = '0;
    gidx    = rr_ptr;
    gnt_any = 1'b0;
    if (RST_N && !full) begin
      for (int off = 1; off <= NUM_LANES; off++) begin
        if (!gnt_any && k_valid[rr_ptr + 2'(off)]) begin
          gnt_any = 1'b1;
          gidx    = rr_ptr + 2'(off);
        end
      end
    end
    if (gnt_any) k_ready[gidx] = 1'b1;
  end

  // Head register tracks whatever will sit at the front after this edge;
  // an empty-after-pop queue takes the incoming write directly.
  always_comb begin
    head_nx = {out_mode, out_userID, out_candidate};
    if (lvl_nx != '0) begin
      if ((level - (AW+1)'(pop)) == '0) head_nx = entry[gidx];
      else                              head_nx = mem[rd_ptr + AW'(pop)];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= entry[gidx];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      rr_ptr        <= 2'd3;
      bad_cmd       <= 1'b0;
      out_mode      <= '0;
      out_userID    <= '0;
      out_candidate <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (gnt_any) rr_ptr <= gidx;
      level   <= lvl_nx;
      bad_cmd <= gnt_any && bad_lane[gidx];
      {out_mode, out_userID, out_candidate} <= head_nx;
    end
  end

`ifdef QUEUE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cycles <= '0;
      drop_count   <= '0;
    end else begin
      if ((|k_valid) && full && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 1'b1;
      if (gnt_any && bad_lane[gidx] && (drop_count != 8'hFF))
        drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ballot_request_queue.sv
// Randomized and directed checks of ballot_request_queue against a queue-based model.
module tb_ballot_request_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        CLK, RST_N;
  logic [3:0]  k_valid;
  logic [7:0]  k_mode;
  logic [15:0] k_uid;
  logic [7:0]  k_cand;
  logic [3:0]  k_ready;
  logic        out_valid, out_ready;
  logic [1:0]  out_mode;
  logic [5:0]  out_userID;
  logic [1:0]  out_candidate;
  logic [AW:0] level;
  logic        bad_cmd;
`ifdef QUEUE_STATS_EN
  logic [15:0] stall_cycles;
  logic [7:0]  drop_count;
`endif

  ballot_request_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .k_valid(k_valid), .k_mode(k_mode),
    .k_uid(k_uid), .k_cand(k_cand), .k_ready(k_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_mode(out_mode), .out_userID(out_userID),
    .out_candidate(out_candidate), .level(level), .bad_cmd(bad_cmd)
`ifdef QUEUE_STATS_EN
    , .stall_cycles(stall_cycles), .drop_count(drop_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { int mode; int uid; int cand; } req_t;
  req_t mq[$];
  int   mptr, last_g, mbad, m_stall, m_drop;
  int   pass_cnt = 0, total_cnt = 0;

  task automatic chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int model_grant();
    if (!RST_N || mq.size() == DEPTH) return -1;
    for (int off = 1; off <= 4; off++)
      if (k_valid[(mptr + off) % 4]) return (mptr + off) % 4;
    return -1;
  endfunction

  task automatic check_all();
    int g;
    if (RST_N) begin
      g = model_grant();
      chk("k_ready", int'(k_ready), (g < 0) ? 0 : (1 << g));
    end
    chk("level", int'(level), mq.size());
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_mode", int'(out_mode), mq[0].mode);
      chk("out_userID", int'(out_userID), mq[0].uid);
      chk("out_candidate", int'(out_candidate), mq[0].cand);
    end
    chk("bad_cmd", int'(bad_cmd), mbad);
`ifdef QUEUE_STATS_EN
    chk("stall_cycles", int'(stall_cycles), m_stall);
    chk("drop_count", int'(drop_count), m_drop);
`endif
  endtask

  task automatic model_update();
    int g, m;
    req_t r;
    if (!RST_N) begin
      mq.delete(); mptr = 3; mbad = 0; last_g = -1; m_stall = 0; m_drop = 0;
      return;
    end
    g = model_grant();
    if ((k_valid != 0) && mq.size() == DEPTH && m_stall < 65535) m_stall++;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    mbad = 0;
    if (g >= 0) begin
      m = int'(k_mode[2*g +: 2]);
      if (m >= 2) begin
        mbad = 1;
        if (m_drop < 255) m_drop++;
      end else begin
        r.mode = m;
        r.uid  = g * 16 + int'(k_uid[4*g +: 4]);
        r.cand = int'(k_cand[2*g +: 2]);
        mq.push_back(r);
      end
      mptr = g;
    end
    last_g = g;
  endtask

  task automatic step();
    #1 check_all();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic set_k(int i, bit v, bit [1:0] m, bit [3:0] u, bit [1:0] c);
    k_valid[i]      = v;
    k_mode[2*i +: 2] = m;
    k_uid[4*i +: 4]  = u;
    k_cand[2*i +: 2] = c;
  endtask

  task automatic do_reset(int cycles);
    RST_N = 1'b0;
    k_valid = '0;
    repeat (cycles) step();
    RST_N = 1'b1;
  endtask

  initial begin
    int n;
    int exp_uid [4];
    k_valid = '0; k_mode = '0; k_uid = '0; k_cand = '0; out_ready = 1'b0;
    mptr = 3; last_g = -1; mbad = 0; m_stall = 0; m_drop = 0;
    @(negedge CLK);

    // reset state
    do_reset(2);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_k_ready", int'(k_ready), 0);
    chk("rst_out_userID", int'(out_userID), 0);

    // fairness: every kiosk always requesting
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_k(i, 1'b1, 2'b01, 4'(5 + i), 2'(i));
      exp_uid[i] = i * 16 + 5 + i;
    end
    for (int s = 0; s < 5; s++) begin
      #1 chk("fair_grant", int'(k_ready), 1 << (s % 4));
      step();
      chk("fair_uid", int'(out_userID), exp_uid[s % 4]);
    end
    k_valid = '0;
    step(); step();

    // single request from kiosk 2
    do_reset(1);
    set_k(2, 1'b1, 2'b01, 4'd5, 2'b11);
    step();
    k_valid = '0;
    #1;
    chk("single_valid", int'(out_valid), 1);
    chk("single_uid", int'(out_userID), 6'b100101);
    chk("single_cand", int'(out_candidate), 3);
    step(); step();

    // backpressure: kiosk 1 streams 9 requests into an 8-deep queue
    do_reset(1);
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      set_k(1, 1'b1, 2'b01, 4'(n), 2'(n % 4));
      step();
      if (last_g == 1) n++;
    end
    #1;
    chk("bp_level", int'(level), 8);
    chk("bp_k_ready", int'(k_ready), 0);
    chk("bp_head_uid", int'(out_userID), 6'b010000);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n < 9; c++) begin
      step();
      if (last_g == 1) n++;
      set_k(1, 1'b1, 2'b01, 4'(n), 2'(n % 4));
    end
    chk("bp_ninth_granted", n, 9);
    k_valid = '0;
    repeat (12) step();

    // bad command from kiosk 3
    do_reset(1);
    out_ready = 1'b0;
    set_k(0, 1'b1, 2'b00, 4'd9, 2'b01);
    step();
    k_valid = '0;
    set_k(3, 1'b1, 2'b10, 4'd2, 2'b00);
    #1 chk("bad_grant", int'(k_ready), 4'b1000);
    step();
    k_valid = '0;
    #1;
    chk("bad_pulse", int'(bad_cmd), 1);
    chk("bad_level", int'(level), 1);
`ifdef QUEUE_STATS_EN
    chk("bad_drop", int'(drop_count), 1);
`endif
    step();

    // mid-operation flush
    do_reset(1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_k(0, 1'b1, 2'b01, 4'(c), 2'b10);
      step();
    end
    #1 chk("flush_pre_level", int'(level), 5);
    do_reset(1);
    out_ready = 1'b1;
    #1;
    chk("flush_level", int'(level), 0);
    chk("flush_valid", int'(out_valid), 0);
    repeat (4) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (last_g == i) k_valid[i] = 1'b0;
        if (!k_valid[i] && ($urandom % 3 == 0))
          set_k(i, 1'b1, ($urandom % 8 < 6) ? 2'($urandom % 2) : 2'(2 + $urandom % 2),
                4'($urandom), 2'($urandom));
      end
      out_ready = ((c / 64) % 3 == 2) ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      RST_N = ($urandom % 300 != 0);
      step();
    end
    RST_N = 1'b1;
    k_valid = '0;
    out_ready = 1'b1;
    repeat (10) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
